apb_result_fifo: RTL and testbench

APB slave that sits on the same APB bus as the execution unit and is driven by the shared controller master. It buffers operation results pushed by the master in a small FIFO so that results can be read back later in order. It decodes its own PSEL bit and also exposes a status register and a flush control. It adds one wait state per transfer, which exercises the master's PREADY handling.

---
 rtl/apb_result_fifo_if.sv | 25 ++
 rtl/apb_result_fifo.sv | 148 ++++++++++++++
 tb/tb_apb_result_fifo.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/apb_result_fifo_if.sv
// rtl/apb_result_fifo_if.sv - APB bus bundle between the controller master and the result FIFO slave
interface apb_result_fifo_if #(
    parameter int SEL_WIDTH  = 3,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [SEL_WIDTH-1:0]  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_result_fifo.sv
// rtl/apb_result_fifo.sv - APB slave buffering results in a small FIFO, one wait state per transfer
module apb_result_fifo #(
    parameter int SEL_WIDTH  = 3,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_BIT    = 2,
    parameter int DEPTH      = 4
) (
    input  logic            i_PCLK,
    input  logic            i_PRESETn,
    apb_result_fifo_if.slave apb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] A_DATA   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  pready_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pslverr_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  sel, setup, access, commit;
    logic                  full, empty, err, push;
    logic [DATA_WIDTH-1:0] status, rdata;
    logic [SEL_WIDTH-1:0]  psel_unused;

    assign psel_unused = apb.PSEL;
    assign sel    = apb.PSEL[SEL_BIT];
    assign setup  = sel && !apb.PENABLE;
    assign access = sel && apb.PENABLE;
    assign commit = (state_q == S_WAIT) && access;
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign status = {(DATA_WIDTH-2)'(count_q), full, empty};

    // The error decision gates every side effect, so an erroring transfer never moves the FIFO.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push     = 1'b0;
        rdata    = '0;
        case (addr_q)
            A_DATA:   err = write_q ? full : empty;
            A_STATUS: err = write_q;
            A_CTRL:   err = 1'b0;
            default:  err = 1'b1;
        endcase
        if (commit && !err) begin
            case (addr_q)
                A_DATA: begin
                    if (write_q) begin
                        push     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        count_d  = count_q + CNT_W'(1);
                    end else begin
                        rdata    = mem_q[rd_ptr_q];
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        count_d  = count_q - CNT_W'(1);
                    end
                end
                A_STATUS: rdata = status;
                A_CTRL: begin
                    if (write_q && wdata_q[0]) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                    end
                end
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            case (state_q)
                S_IDLE: begin
                    if (setup) begin
                        state_q <= S_WAIT;
                        addr_q  <= apb.PADDR;
                        write_q <= apb.PWRITE;
                        wdata_q <= apb.PWDATA;
                    end
                end
                S_WAIT: begin
                    if (access) begin
                        state_q   <= S_RESP;
                        pready_q  <= 1'b1;
                        prdata_q  <= (!write_q && !err) ? rdata : '0;
                        pslverr_q <= err;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                    if (setup) begin
                        state_q <= S_WAIT;
                        addr_q  <= apb.PADDR;
                        write_q <= apb.PWRITE;
                        wdata_q <= apb.PWDATA;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Storage is never reset or cleared; flush only rewinds the pointers.
    always_ff @(posedge i_PCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_q;
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PRDATA  = prdata_q;
    assign apb.PSLVERR = pslverr_q;
endmodule

// File: tb/tb_apb_result_fifo.sv
// tb/tb_apb_result_fifo.sv - self-checking bench for apb_result_fifo against a queue model
module tb_apb_result_fifo;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    byte unsigned model_q[$];

    apb_result_fifo_if #(.SEL_WIDTH(3), .ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

    apb_result_fifo #(
        .SEL_WIDTH(3), .ADDR_WIDTH(2), .DATA_WIDTH(8), .SEL_BIT(2), .DEPTH(DEPTH)
    ) dut (
        .i_PCLK   (clk),
        .i_PRESETn(rst_n),
        .apb      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Returns lat = number of access cycles until PREADY, or 0 if it never came.
    task automatic apb_xfer(input logic [1:0] a, input logic w, input logic [7:0] d,
                            input logic [2:0] sel, output logic [7:0] rd, output logic er,
                            output int lat);
        @(posedge clk); #1;
        bus.PSEL = sel; bus.PADDR = a; bus.PWRITE = w; bus.PWDATA = d; bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        lat = 1;
        while (!bus.PREADY && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = bus.PRDATA;
        er = bus.PSLVERR;
        if (!bus.PREADY) lat = 0;
        bus.PSEL = '0; bus.PENABLE = 1'b0;
    endtask

    function automatic void model_op(input logic [1:0] a, input logic w, input logic [7:0] d,
                                     output logic [7:0] rd, output logic er);
        int n;
        rd = 8'h00;
        er = 1'b0;
        n  = model_q.size();
        case (a)
            2'd0: begin
                if (w) begin
                    if (n == DEPTH) er = 1'b1;
                    else model_q.push_back(d);
                end else begin
                    if (n == 0) er = 1'b1;
                    else rd = model_q.pop_front();
                end
            end
            2'd1: begin
                if (w) er = 1'b1;
                else rd = 8'(n * 4 + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0));
            end
            2'd2: begin
                if (w && d[0]) model_q.delete();
            end
            default: er = 1'b1;
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [1:0] a, input logic w, input logic [7:0] d);
        logic [7:0] rd, exp_rd;
        logic       er, exp_er;
        int         lat;
        model_op(a, w, d, exp_rd, exp_er);
        apb_xfer(a, w, d, 3'b100, rd, er, lat);
        check({tag, ".lat"}, lat, 2);
        check({tag, ".prdata"}, rd, exp_rd);
        check({tag, ".pslverr"}, er, exp_er);
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;
        int         lat;
        int         r;

        bus.PSEL = '0; bus.PADDR = '0; bus.PWRITE = 1'b0; bus.PWDATA = '0; bus.PENABLE = 1'b0;
        #12;
        check("rst.pready", bus.PREADY, 0);
        check("rst.prdata", bus.PRDATA, 0);
        check("rst.pslverr", bus.PSLVERR, 0);
        rst_n = 1'b1;

        do_op("status0", 2'd1, 1'b0, 8'h00);

        do_op("push_a1", 2'd0, 1'b1, 8'hA1);
        do_op("push_b2", 2'd0, 1'b1, 8'hB2);
        do_op("push_c3", 2'd0, 1'b1, 8'hC3);
        do_op("status3", 2'd1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) do_op("pop3", 2'd0, 1'b0, 8'h00);
        do_op("status_e", 2'd1, 1'b0, 8'h00);

        for (int i = 0; i < 4; i++) do_op("fill", 2'd0, 1'b1, 8'(8'h10 + i));
        do_op("push_full", 2'd0, 1'b1, 8'hFF);
        do_op("status_full", 2'd1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) do_op("drain", 2'd0, 1'b0, 8'h00);

        for (int i = 0; i < 3; i++) do_op("wrap_p3", 2'd0, 1'b1, 8'(8'h30 + i));
        for (int i = 0; i < 3; i++) do_op("wrap_r3", 2'd0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) do_op("wrap_p4", 2'd0, 1'b1, 8'(8'h40 + i));
        for (int i = 0; i < 4; i++) do_op("wrap_r4", 2'd0, 1'b0, 8'h00);
        do_op("wrap_status", 2'd1, 1'b0, 8'h00);

        do_op("fl_p1", 2'd0, 1'b1, 8'h61);
        do_op("fl_p2", 2'd0, 1'b1, 8'h62);
        do_op("flush", 2'd2, 1'b1, 8'h01);
        do_op("fl_status", 2'd1, 1'b0, 8'h00);
        do_op("wr_addr3", 2'd3, 1'b1, 8'h5A);
        do_op("wr_status", 2'd1, 1'b1, 8'h5A);

        apb_xfer(2'd0, 1'b1, 8'h77, 3'b010, rd, er, lat);
        check("foreign.lat", lat, 0);
        do_op("foreign_status", 2'd1, 1'b0, 8'h00);

        do_op("rst_p1", 2'd0, 1'b1, 8'h21);
        @(posedge clk); #1;
        bus.PSEL = 3'b100; bus.PADDR = 2'd0; bus.PWRITE = 1'b1; bus.PWDATA = 8'h55; bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.pready", bus.PREADY, 0);
        @(posedge clk); #1;
        check("midrst.pready2", bus.PREADY, 0);
        bus.PSEL = '0; bus.PENABLE = 1'b0;
        model_q.delete();
        #3;
        rst_n = 1'b1;
        do_op("midrst_status", 2'd1, 1'b0, 8'h00);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      do_op("rnd_push", 2'd0, 1'b1, 8'($urandom));
            else if (r < 75) do_op("rnd_pop", 2'd0, 1'b0, 8'h00);
            else if (r < 85) do_op("rnd_status", 2'd1, 1'b0, 8'h00);
            else if (r < 90) do_op("rnd_ctrl_w", 2'd2, 1'b1, 8'($urandom));
            else if (r < 94) do_op("rnd_ctrl_r", 2'd2, 1'b0, 8'h00);
            else if (r < 97) do_op("rnd_status_w", 2'd1, 1'b1, 8'($urandom));
            else             do_op("rnd_addr3", 2'd3, 1'($urandom), 8'($urandom));
        end

        @(posedge clk); #1;
        check("idle.pready", bus.PREADY, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
